n64_cfg_mailbox: RTL and testbench
==================================

Name: n64_cfg_mailbox

Overview:
- N64-side command mailbox: decodes 16-bit N64 PI halfword accesses to the SC64 config window and assembles them into 32-bit DATA0/DATA1/COMMAND words.
- Issues cmd_request to the CPU config register block.
- Exposes the CPU-owned status and response data back to the N64.
- Gated by an N64-visible unlock key sequence.

Parameters:
- VERSION, 32'h5343_7632, value returned by the VERSION register.
- UNLOCK_KEY_0, 32'h5F55_4E4C, first unlock key word.
- UNLOCK_KEY_1, 32'h4F43_4B5F, second unlock key word.
- LOCK_KEY, 32'hFFFF_FFFF, relock key word.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- n64_soft_reset  in  1  N64 NMI/soft-reset pulse.
- n64_request  in  1  single-cycle PI access strobe.
- n64_write  in  1  1 = write, 0 = read; sampled with n64_request.
- n64_address  in  4  halfword index: [3:1] word select, [0] 0 = upper half, 1 = lower half.
- n64_wdata  in  16  PI write halfword.
- n64_rdata  out  16  PI read halfword; valid while n64_ack = 1.
- n64_ack  out  1  access acknowledge.
- cpu_ready  in  1  CPU firmware ready.
- cpu_busy  in  1  CPU processing a command.
- cmd_error  in  1  last command failed.
- cpu_data_write  in  2  CPU write strobes for DATA0 [0] / DATA1 [1].
- cpu_wdata  in  32  CPU write data.
- cmd_request  out  1  one-cycle command issue pulse.
- cmd  out  8  latched command byte.
- data_0  out  32  DATA0 register.
- data_1  out  32  DATA1 register.

Behaviour:
- Register map, by word (n64_address[3:1]):
  - 0 = SCR. Read: {busy, cmd_error, 30'd0}. Write: COMMAND; low byte of the committed word becomes cmd.
  - 1 = DATA0.
  - 2 = DATA1.
  - 3 = VERSION (read-only).
  - 4 = KEY (write-only, reads 0).
  - 5–7 = read 0, writes ignored.
- Reset values: n64_ack=0, n64_rdata=0, cmd_request=0, cmd=0, data_0=0, data_1=0, key FSM=LOCKED, cmd_pending=0, both halfword buffers=0.
- Ack: n64_ack is registered, 1 cycle after n64_request, high for exactly 1 cycle. n64_rdata is combinational from the captured read value and is 0 when n64_ack=0.
- Write assembly:
  - Upper-half write stores n64_wdata into wbuf_hi; no commit.
  - Lower-half write commits {wbuf_hi, n64_wdata} to the selected word in the same cycle as the request.
  - A lower-half write without a preceding upper write commits the current wbuf_hi.
- Read coherency:
  - An upper-half read returns word[31:16] and snapshots word[15:0] into rbuf_lo.
  - A lower-half read returns rbuf_lo, not the live value.
- Command issue:
  - A COMMAND commit issues cmd_request (1 cycle, the cycle after commit) and latches cmd only if: UNLOCKED, cpu_ready=1, cpu_busy=0 and cmd_pending=0.
  - Otherwise the command is dropped silently.
  - cmd_pending sets on issue and clears on the first cycle cpu_busy=1.
  - Status busy = cpu_busy | cmd_pending. This covers the latency before the CPU raises busy.
- DATA writes from N64: ignored while busy=1.
- CPU/N64 collision: CPU writes (cpu_data_write) always apply. If a CPU write and an N64 commit hit the same DATA register in the same cycle, the CPU value wins.
- Key FSM, advanced on KEY commits only:
  - LOCKED: UNLOCK_KEY_0 -> KEY1_OK; any other value -> LOCKED.
  - KEY1_OK: UNLOCK_KEY_1 -> UNLOCKED; any other value -> LOCKED.
  - UNLOCKED: LOCK_KEY -> LOCKED; any other value -> UNLOCKED.
- While not UNLOCKED:
  - Reads of every word return 0; ack still occurs.
  - All commits other than KEY are ignored.
- n64_soft_reset:
  - Key FSM -> LOCKED; wbuf_hi=0; rbuf_lo=0.
  - data_0, data_1 and cmd are unchanged.
  - A cmd_pending already set remains set until busy is seen.
- reset mid-access: the pending ack is cancelled (n64_ack=0 the next cycle).

Optional Feature:
- Macro: N64_CFG_KEY_LOCK_EN.
- Defined: the key FSM operates as described.
- Undefined: the block is permanently UNLOCKED; KEY writes are ignored; n64_soft_reset does not lock.

Test Plan:
- Read before unlock: read word 3 upper/lower -> n64_rdata 0x0000 both, each n64_ack 1 cycle after its request.
- Unlock then read VERSION: KEY writes 0x5F554E4C, 0x4F434B5F; read word 3 upper/lower -> 0x5343 then 0x7632.
- Command issue: unlocked, cpu_ready=1, DATA0=0x12345678, COMMAND=0x00000053 -> one cmd_request pulse; cmd=0x53; data_0=0x12345678; SCR upper read=0x8000 until cpu_busy falls.
- Back-to-back commands: second COMMAND commit within 2 cycles of the first, before cpu_busy rises -> no second cmd_request.
- Collision: N64 DATA1 lower commit and cpu_data_write=2'b10 with cpu_wdata=0xCAFEBABE in the same cycle -> data_1=0xCAFEBABE.
- Bad key / soft reset: KEY 0x5F554E4C then 0x00000000 -> LOCKED (SCR reads 0). After unlocking, an n64_soft_reset pulse -> VERSION reads 0 again.

Source files
------------

// File: rtl/n64_cfg_mailbox.sv
// ============================================================================
//  n64_cfg_mailbox
//  N64 PI halfword mailbox for the SC64 config window: assembles DATA0/DATA1/
//  COMMAND words, issues commands to the CPU and returns status/response data.
//  Optional key gating: define N64_CFG_KEY_LOCK_EN to enable the unlock FSM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module n64_cfg_mailbox #(
    parameter logic [31:0] VERSION      = 32'h5343_7632,
    parameter logic [31:0] UNLOCK_KEY_0 = 32'h5F55_4E4C,
    parameter logic [31:0] UNLOCK_KEY_1 = 32'h4F43_4B5F,
    parameter logic [31:0] LOCK_KEY     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        n64_soft_reset,
    input  logic        n64_request,
    input  logic        n64_write,
    input  logic [3:0]  n64_address,
    input  logic [15:0] n64_wdata,
    output logic [15:0] n64_rdata,
    output logic        n64_ack,
    input  logic        cpu_ready,
    input  logic        cpu_busy,
    input  logic        cmd_error,
    input  logic [1:0]  cpu_data_write,
    input  logic [31:0] cpu_wdata,
    output logic        cmd_request,
    output logic [7:0]  cmd,
    output logic [31:0] data_0,
    output logic [31:0] data_1
);

    localparam logic [2:0] W_SCR     = 3'd0;
    localparam logic [2:0] W_DATA0   = 3'd1;
    localparam logic [2:0] W_DATA1   = 3'd2;
    localparam logic [2:0] W_VERSION = 3'd3;
    localparam logic [2:0] W_KEY     = 3'd4;

    logic [15:0] wbuf_hi_q, wbuf_hi_d;
    logic [15:0] rbuf_lo_q, rbuf_lo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q;
    logic        cmd_request_q, cmd_request_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_pending_q, cmd_pending_d;
    logic [31:0] data_0_q, data_0_d;
    logic [31:0] data_1_q, data_1_d;

    logic        unlocked;
    logic [2:0]  word_sel;
    logic        lower_half;
    logic        wr_upper;
    logic        wr_commit;
    logic        rd_access;
    logic [31:0] commit_word;
    logic [31:0] live_word;
    logic        busy;
    logic        issue_ok;

    assign word_sel    = n64_address[3:1];
    assign lower_half  = n64_address[0];
    assign wr_upper    = n64_request &  n64_write & ~lower_half;
    assign wr_commit   = n64_request &  n64_write &  lower_half;
    assign rd_access   = n64_request & ~n64_write;
    assign commit_word = {wbuf_hi_q, n64_wdata};

    // Pending bit bridges the gap between issuing a command and the CPU raising busy
    assign busy     = cpu_busy | cmd_pending_q;
    assign issue_ok = unlocked & cpu_ready & ~cpu_busy & ~cmd_pending_q;

`ifdef N64_CFG_KEY_LOCK_EN
    typedef enum logic [1:0] {
        KEY_LOCKED   = 2'd0,
        KEY_KEY1_OK  = 2'd1,
        KEY_UNLOCKED = 2'd2
    } key_state_t;

    key_state_t key_q, key_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= KEY_LOCKED;
        end else begin
            key_q <= key_d;
        end
    end

    always_comb begin
        key_d = key_q;
        if (n64_soft_reset) begin
            key_d = KEY_LOCKED;
        end else if (wr_commit && (word_sel == W_KEY)) begin
            case (key_q)
                KEY_LOCKED:   key_d = (commit_word == UNLOCK_KEY_0) ? KEY_KEY1_OK : KEY_LOCKED;
                KEY_KEY1_OK:  key_d = (commit_word == UNLOCK_KEY_1) ? KEY_UNLOCKED : KEY_LOCKED;
                KEY_UNLOCKED: key_d = (commit_word == LOCK_KEY) ? KEY_LOCKED : KEY_UNLOCKED;
                default:      key_d = KEY_LOCKED;
            endcase
        end
    end

    assign unlocked = (key_q == KEY_UNLOCKED);
`else
    assign unlocked = 1'b1;
`endif

    always_comb begin
        live_word = 32'd0;
        case (word_sel)
            W_SCR:     live_word = {busy, cmd_error, 30'd0};
            W_DATA0:   live_word = data_0_q;
            W_DATA1:   live_word = data_1_q;
            W_VERSION: live_word = VERSION;
            W_KEY:     live_word = 32'd0;
            default:   live_word = 32'd0;
        endcase
        if (!unlocked) begin
            live_word = 32'd0;
        end
    end

    always_comb begin
        wbuf_hi_d     = wbuf_hi_q;
        rbuf_lo_d     = rbuf_lo_q;
        rdata_d       = 16'd0;
        cmd_request_d = 1'b0;
        cmd_d         = cmd_q;
        cmd_pending_d = cmd_pending_q;
        data_0_d      = data_0_q;
        data_1_d      = data_1_q;

        if (cmd_pending_q && cpu_busy) begin
            cmd_pending_d = 1'b0;
        end

        if (wr_upper) begin
            wbuf_hi_d = n64_wdata;
        end

        // Upper read snapshots the low half so a split read sees one coherent word
        if (rd_access) begin
            if (!lower_half) begin
                rdata_d   = live_word[31:16];
                rbuf_lo_d = live_word[15:0];
            end else begin
                rdata_d = unlocked ? rbuf_lo_q : 16'd0;
            end
        end

        if (wr_commit && unlocked) begin
            case (word_sel)
                W_SCR: begin
                    if (issue_ok) begin
                        cmd_request_d = 1'b1;
                        cmd_d         = commit_word[7:0];
                        cmd_pending_d = 1'b1;
                    end
                end
                W_DATA0: if (!busy) data_0_d = commit_word;
                W_DATA1: if (!busy) data_1_d = commit_word;
                default: ;
            endcase
        end

        // CPU writes land last so they win any same-cycle collision
        if (cpu_data_write[0]) data_0_d = cpu_wdata;
        if (cpu_data_write[1]) data_1_d = cpu_wdata;

        if (n64_soft_reset) begin
            wbuf_hi_d = 16'd0;
            rbuf_lo_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_hi_q     <= 16'd0;
            rbuf_lo_q     <= 16'd0;
            rdata_q       <= 16'd0;
            ack_q         <= 1'b0;
            cmd_request_q <= 1'b0;
            cmd_q         <= 8'd0;
            cmd_pending_q <= 1'b0;
            data_0_q      <= 32'd0;
            data_1_q      <= 32'd0;
        end else begin
            wbuf_hi_q     <= wbuf_hi_d;
            rbuf_lo_q     <= rbuf_lo_d;
            rdata_q       <= rdata_d;
            ack_q         <= n64_request;
            cmd_request_q <= cmd_request_d;
            cmd_q         <= cmd_d;
            cmd_pending_q <= cmd_pending_d;
            data_0_q      <= data_0_d;
            data_1_q      <= data_1_d;
        end
    end

    assign n64_ack     = ack_q;
    assign n64_rdata   = ack_q ? rdata_q : 16'd0;
    assign cmd_request = cmd_request_q;
    assign cmd         = cmd_q;
    assign data_0      = data_0_q;
    assign data_1      = data_1_q;

endmodule

`default_nettype wire

// File: tb/tb_n64_cfg_mailbox.sv
// ============================================================================
//  tb_n64_cfg_mailbox
//  Scoreboard bench for n64_cfg_mailbox; expectations follow N64_CFG_KEY_LOCK_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_n64_cfg_mailbox;

`ifdef N64_CFG_KEY_LOCK_EN
    localparam logic [15:0] LK_VER_HI = 16'h0000;
    localparam logic [15:0] LK_VER_LO = 16'h0000;
    localparam logic [15:0] LK_SCR_ERR = 16'h0000;
    localparam logic [31:0] WBUF_TEST_D0 = 32'h1234_5678;
`else
    localparam logic [15:0] LK_VER_HI = 16'h5343;
    localparam logic [15:0] LK_VER_LO = 16'h7632;
    localparam logic [15:0] LK_SCR_ERR = 16'h4000;
    localparam logic [31:0] WBUF_TEST_D0 = 32'h0000_0001;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        n64_soft_reset = 1'b0;
    logic        n64_request = 1'b0;
    logic        n64_write = 1'b0;
    logic [3:0]  n64_address = 4'd0;
    logic [15:0] n64_wdata = 16'd0;
    logic [15:0] n64_rdata;
    logic        n64_ack;
    logic        cpu_ready = 1'b0;
    logic        cpu_busy = 1'b0;
    logic        cmd_error = 1'b0;
    logic [1:0]  cpu_data_write = 2'b00;
    logic [31:0] cpu_wdata = 32'd0;
    logic        cmd_request;
    logic [7:0]  cmd;
    logic [31:0] data_0;
    logic [31:0] data_1;

    n64_cfg_mailbox dut (
        .clk            (clk),
        .reset          (reset),
        .n64_soft_reset (n64_soft_reset),
        .n64_request    (n64_request),
        .n64_write      (n64_write),
        .n64_address    (n64_address),
        .n64_wdata      (n64_wdata),
        .n64_rdata      (n64_rdata),
        .n64_ack        (n64_ack),
        .cpu_ready      (cpu_ready),
        .cpu_busy       (cpu_busy),
        .cmd_error      (cmd_error),
        .cpu_data_write (cpu_data_write),
        .cpu_wdata      (cpu_wdata),
        .cmd_request    (cmd_request),
        .cmd            (cmd),
        .data_0         (data_0),
        .data_1         (data_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] d;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   req_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_request) req_cnt <= req_cnt + 1;
    end

    // Monitor: every ack must match the oldest issued access, one cycle later
    always @(negedge clk) begin
        exp_t e;
        if (n64_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_ack: got ack=1 want no ack (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc + 1) begin
                    bad++;
                    $display("FAIL ack_latency: got cycle %0d want cycle %0d", cyc, e.cyc + 1);
                end
                if (!e.wr) begin
                    total++;
                    if (n64_rdata !== e.d) begin
                        bad++;
                        $display("FAIL rdata: got %h want %h (cycle %0d)", n64_rdata, e.d, cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [3:0] a, input logic [15:0] d, input logic [15:0] expv);
        exp_t e;
        n64_request = 1'b1;
        n64_write   = wr;
        n64_address = a;
        n64_wdata   = d;
        e.wr = wr;
        e.d = expv;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic pi(input bit wr, input logic [3:0] a, input logic [15:0] d, input logic [15:0] expv);
        issue(wr, a, d, expv);
        tick();
        n64_request = 1'b0;
        tick();
    endtask

    task automatic wr32(input logic [2:0] w, input logic [31:0] v);
        pi(1'b1, {w, 1'b0}, v[31:16], 16'd0);
        pi(1'b1, {w, 1'b1}, v[15:0], 16'd0);
    endtask

    task automatic rd32(input logic [2:0] w, input logic [31:0] expv);
        pi(1'b0, {w, 1'b0}, 16'd0, expv[31:16]);
        pi(1'b0, {w, 1'b1}, 16'd0, expv[15:0]);
    endtask

    task automatic soft_reset_pulse();
        n64_soft_reset = 1'b1;
        tick();
        n64_soft_reset = 1'b0;
        tick();
    endtask

    initial begin
        int c0;
        #1;
        repeat (3) tick();
        check("reset_ack", {31'd0, n64_ack}, 32'd0);
        check("reset_rdata", {16'd0, n64_rdata}, 32'd0);
        check("reset_cmd_request", {31'd0, cmd_request}, 32'd0);
        check("reset_cmd", {24'd0, cmd}, 32'd0);
        check("reset_data_0", data_0, 32'd0);
        check("reset_data_1", data_1, 32'd0);
        reset = 1'b0;
        tick();

        // Before unlock
        rd32(3'd3, {LK_VER_HI, LK_VER_LO});

        // Unlock and read VERSION
        wr32(3'd4, 32'h5F55_4E4C);
        wr32(3'd4, 32'h4F43_4B5F);
        rd32(3'd3, 32'h5343_7632);

        // Command issue
        cpu_ready = 1'b1;
        wr32(3'd1, 32'h1234_5678);
        check("data0_write", data_0, 32'h1234_5678);
        c0 = req_cnt;
        wr32(3'd0, 32'h0000_0053);
        tick();
        check("cmd_issue_pulses", req_cnt, c0 + 1);
        check("cmd_latched", {24'd0, cmd}, 32'h53);
        pi(1'b0, 4'b0000, 16'd0, 16'h8000);
        cpu_busy = 1'b1;
        tick();
        pi(1'b0, 4'b0000, 16'd0, 16'h8000);
        cpu_busy = 1'b0;
        tick();
        pi(1'b0, 4'b0000, 16'd0, 16'h0000);
        check("cmd_single_pulse", req_cnt, c0 + 1);

        // Back-to-back commands: second one is dropped
        pi(1'b1, 4'b0000, 16'h0000, 16'd0);
        c0 = req_cnt;
        issue(1'b1, 4'b0001, 16'h0011, 16'd0);
        tick();
        issue(1'b1, 4'b0001, 16'h0022, 16'd0);
        tick();
        n64_request = 1'b0;
        repeat (3) tick();
        check("b2b_pulses", req_cnt, c0 + 1);
        check("b2b_cmd", {24'd0, cmd}, 32'h11);
        cpu_busy = 1'b1;
        tick();

        // DATA writes ignored while busy
        wr32(3'd1, 32'hDEAD_BEEF);
        check("data0_busy_ignored", data_0, 32'h1234_5678);
        cpu_busy = 1'b0;
        tick();

        // DATA1 write, collision, and read coherency
        wr32(3'd2, 32'h0102_0304);
        check("data1_write", data_1, 32'h0102_0304);
        pi(1'b1, 4'b0100, 16'hAAAA, 16'd0);
        issue(1'b1, 4'b0101, 16'h5555, 16'd0);
        cpu_data_write = 2'b10;
        cpu_wdata = 32'hCAFE_BABE;
        tick();
        n64_request = 1'b0;
        cpu_data_write = 2'b00;
        tick();
        check("collision_cpu_wins", data_1, 32'hCAFE_BABE);
        pi(1'b0, 4'b0100, 16'd0, 16'hCAFE);
        cpu_data_write = 2'b10;
        cpu_wdata = 32'h1111_2222;
        tick();
        cpu_data_write = 2'b00;
        pi(1'b0, 4'b0101, 16'd0, 16'hBABE);
        pi(1'b0, 4'b0100, 16'd0, 16'h1111);

        // Key handling
        cmd_error = 1'b1;
`ifdef N64_CFG_KEY_LOCK_EN
        wr32(3'd4, 32'hFFFF_FFFF);
        rd32(3'd3, 32'h0000_0000);
        wr32(3'd4, 32'h5F55_4E4C);
        wr32(3'd4, 32'h0000_0000);
        pi(1'b0, 4'b0000, 16'd0, LK_SCR_ERR);
        wr32(3'd4, 32'h4F43_4B5F);
        pi(1'b0, 4'b0110, 16'd0, 16'h0000);
        wr32(3'd4, 32'h5F55_4E4C);
        wr32(3'd4, 32'h4F43_4B5F);
        pi(1'b0, 4'b0000, 16'd0, 16'h4000);
`else
        wr32(3'd4, 32'hFFFF_FFFF);
        pi(1'b0, 4'b0000, 16'd0, LK_SCR_ERR);
`endif
        cmd_error = 1'b0;

        // Soft reset
        soft_reset_pulse();
        pi(1'b0, 4'b0110, 16'd0, LK_VER_HI);
        check("soft_reset_data0", data_0, 32'h1234_5678);
        check("soft_reset_data1", data_1, 32'h1111_2222);
        check("soft_reset_cmd", {24'd0, cmd}, 32'h11);
        pi(1'b1, 4'b0010, 16'hBEEF, 16'd0);
        soft_reset_pulse();
        pi(1'b1, 4'b0011, 16'h0001, 16'd0);
        check("soft_reset_wbuf", data_0, WBUF_TEST_D0);

        // Reset during an access cancels the ack
        issue(1'b0, 4'b0110, 16'd0, 16'd0);
        void'(exp_q.pop_back());
        reset = 1'b1;
        tick();
        n64_request = 1'b0;
        check("reset_cancels_ack", {31'd0, n64_ack}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("reset_mid_data0", data_0, 32'd0);
        check("reset_mid_cmd", {24'd0, cmd}, 32'd0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
